// File: rtl/comparator_bist.sv
// ---------------------------------------------------------------------------
// comparator_bist
//
// Built-in self-test engine for an external 8-bit magnitude comparator.
// A run drives three fixed operand pairs, followed by num_tests pseudo-random
// pairs taken from a 16-bit Fibonacci LFSR. For each pair the engine waits
// SETTLE clock edges, samples the comparator's greater/less/equal outputs,
// and compares them against an internally computed unsigned result.
//
// Parameters
//   SETTLE       : edges between driving a/b and sampling the results (1..15)
//
// Ports
//   clk          : rising-edge clock
//   rst_n        : asynchronous active-low reset
//   start        : begin a run (honoured only while idle or done)
//   num_tests    : number of random vectors, latched on start
//   a, b         : operands presented to the comparator under test
//   greater      : comparator result a>b
//   less         : comparator result a<b
//   equal        : comparator result a==b
//   busy         : run in progress
//   done         : run finished, result outputs valid
//   pass         : last run saw no mismatching vector
//   test_count   : vectors checked in this run
//   fail_count   : mismatching vectors, saturating at 255
//   first_fail_a : operand a of the first mismatching vector
//   first_fail_b : operand b of the first mismatching vector
// ---------------------------------------------------------------------------
module comparator_bist #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] num_tests,
    output logic [7:0] a,
    output logic [7:0] b,
    input  logic       greater,
    input  logic       less,
    input  logic       equal,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [8:0] test_count,
    output logic [7:0] fail_count,
    output logic [7:0] first_fail_a,
    output logic [7:0] first_fail_b
);

    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_DRIVE  = 2'd1;
    localparam logic [1:0]  ST_CHECK  = 2'd2;
    localparam logic [1:0]  ST_DONE   = 2'd3;

    localparam logic [15:0] LFSR_SEED   = 16'hACE1;
    localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE - 1);

    logic [1:0]  state_r;
    logic [7:0]  num_tests_r;
    logic [8:0]  idx_r;
    logic [3:0]  settle_cnt_r;
    logic [15:0] lfsr_r;

    logic [2:0]  expected_s;
    logic [2:0]  sampled_s;
    logic        mismatch_s;
    logic        last_vec_s;
    logic [8:0]  next_idx_s;

    // Fibonacci LFSR step, taps 16,14,13,11 (shift toward bit 0).
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        lfsr_step = {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

    // Reference result for the operands currently driven, and the mismatch flag.
    always_comb begin
        expected_s = 3'b000;
        sampled_s  = {greater, less, equal};
        if (a > b) begin
            expected_s = 3'b100;
        end else if (a < b) begin
            expected_s = 3'b010;
        end else begin
            expected_s = 3'b001;
        end
        // Any bit difference counts, so a non-one-hot response also fails.
        mismatch_s = (sampled_s != expected_s);
    end

    // Vector bookkeeping: total vectors = 3 directed + num_tests random.
    always_comb begin
        next_idx_s = idx_r + 9'd1;
        last_vec_s = (idx_r == ({1'b0, num_tests_r} + 9'd2));
    end

    // Run sequencer: operand drive, settle timing, result scoring, status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            num_tests_r  <= 8'd0;
            idx_r        <= 9'd0;
            settle_cnt_r <= 4'd0;
            lfsr_r       <= LFSR_SEED;
            a            <= 8'd0;
            b            <= 8'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            test_count   <= 9'd0;
            fail_count   <= 8'd0;
            first_fail_a <= 8'd0;
            first_fail_b <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        // Every run starts from identical state, so a run after
                        // an interrupted one reproduces a fresh sequence.
                        num_tests_r  <= num_tests;
                        idx_r        <= 9'd0;
                        settle_cnt_r <= 4'd0;
                        lfsr_r       <= LFSR_SEED;
                        a            <= 8'hF0;
                        b            <= 8'h0F;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        pass         <= 1'b0;
                        test_count   <= 9'd0;
                        fail_count   <= 8'd0;
                        first_fail_a <= 8'd0;
                        first_fail_b <= 8'd0;
                        state_r      <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (settle_cnt_r == SETTLE_LAST) begin
                        // Sample edge: score the comparator outputs now.
                        test_count <= test_count + 9'd1;
                        if (mismatch_s) begin
                            if (fail_count != 8'hFF) begin
                                fail_count <= fail_count + 8'd1;
                            end
                            // fail_count is still zero only before the first failure.
                            if (fail_count == 8'd0) begin
                                first_fail_a <= a;
                                first_fail_b <= b;
                            end
                        end
                        state_r <= ST_CHECK;
                    end else begin
                        settle_cnt_r <= settle_cnt_r + 4'd1;
                    end
                end
                ST_CHECK: begin
                    if (last_vec_s) begin
                        // a/b are left at the last vector while done.
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (fail_count == 8'd0);
                        state_r <= ST_DONE;
                    end else begin
                        idx_r        <= next_idx_s;
                        settle_cnt_r <= 4'd0;
                        state_r      <= ST_DRIVE;
                        case (next_idx_s)
                            9'd1: begin
                                a <= 8'hAA;
                                b <= 8'hB0;
                            end
                            9'd2: begin
                                a <= 8'hFF;
                                b <= 8'hFF;
                            end
                            default: begin
                                // Random vector uses the current LFSR value,
                                // then the LFSR moves on for the next one.
                                a      <= lfsr_r[15:8];
                                b      <= lfsr_r[7:0];
                                lfsr_r <= lfsr_step(lfsr_r);
                            end
                        endcase
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
